// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the handshaked data memory.
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int unsigned LANE_W     = 8;
    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int unsigned MAX_DATA_W = 512;
    localparam int unsigned MAX_LANES  = MAX_DATA_W / LANE_W;

    // Byte-lane merge: lanes with be set come from new_word, others from old_word.
    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_LANES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (be[i]) begin
                merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage with one per-lane-enabled write port and an
// asynchronous read port. Addresses at or above DEPTH read as zero and
// are never written.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned ADDR_W = 8,
    parameter  int unsigned DEPTH  = 2**ADDR_W,
    localparam int unsigned LANES  = DATA_W / LANE_W
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = ({1'b0, waddr} < DEPTH_L);
    assign rd_ok = ({1'b0, raddr} < DEPTH_L);

    // Per-lane write of the addressed word.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    mem[waddr[IDX_W-1:0]][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rdata = rd_ok ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/data_mem_hs.sv
// Handshaked data memory: zero-fill after reset, then one request per
// cycle over valid/ready with a single registered response slot.
module data_mem_hs
    import data_mem_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned ADDR_W = 8,
    parameter  int unsigned DEPTH  = 2**ADDR_W,
    localparam int unsigned LANES  = DATA_W / LANE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wren,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int unsigned     CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              in_range;
    logic [LANES-1:0]  eff_be;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;

    logic [LANES-1:0]  arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;

    assign in_range  = ({1'b0, req_addr} < DEPTH_L);
    assign req_ready = (state_q == RUN) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign init_done = (state_q == RUN);

    // Reads use byte enables of zero so the merge returns the stored word.
    assign eff_be = req_wren ? req_be : '0;
    assign merged = DATA_W'(lane_merge(MAX_DATA_W'(old_word),
                                       MAX_DATA_W'(req_wdata),
                                       MAX_LANES'(eff_be)));

    data_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (req_addr),
        .rdata (old_word)
    );

    // State and clear-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk the clear counter over every word, then run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Array write-port mux: zero-fill during CLEAR, in-range writes during RUN.
    always_comb begin
        arr_we    = '0;
        arr_waddr = req_addr;
        arr_wdata = req_wdata;
        if (rst_n) begin
            if (state_q == CLEAR) begin
                arr_we    = '1;
                arr_waddr = ADDR_W'(cnt_q);
                arr_wdata = '0;
            end else if (accept && req_wren && in_range) begin
                arr_we = req_be;
            end
        end
    end

    // Response register: loads on accept, clears when consumed, holds under stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= in_range ? merged : '0;
            rsp_err   <= !in_range;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench for data_mem_hs against a word-array reference model.
module tb_data_mem_hs;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 12;
    localparam int unsigned LANES  = DATA_W / 8;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LANES-1:0]  req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];

    data_mem_hs #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wren  (req_wren),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_zero();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    endfunction

    // One accepted request: update the word array and give the expected response.
    function automatic void model_access(input bit wr, input int addr, input logic [15:0] wdata,
                                         input logic [1:0] be,
                                         output logic [15:0] exp_data, output logic exp_err);
        logic [15:0] mask;
        if (addr >= int'(DEPTH)) begin
            exp_data = 16'h0000;
            exp_err  = 1'b1;
        end else begin
            if (wr) begin
                mask = (be[0] ? 16'h00FF : 16'h0000) | (be[1] ? 16'hFF00 : 16'h0000);
                ref_mem[addr] = (ref_mem[addr] & ~mask) | (wdata & mask);
            end
            exp_data = ref_mem[addr];
            exp_err  = 1'b0;
        end
    endfunction

    // Issue one request, check its response, optionally stall the consumer.
    task automatic do_req(input bit wr, input int addr, input logic [15:0] wdata,
                          input logic [1:0] be, input int stall);
        logic [15:0] ed;
        logic        ee;
        int          n;
        req_valid = 1'b1;
        req_wren  = wr;
        req_addr  = ADDR_W'(addr);
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_before_accept", req_ready, 1);
        tick();
        model_access(wr, addr, wdata, be, ed, ee);
        req_valid = 1'b0;
        chk("rsp_valid", rsp_valid, 1);
        chk(wr ? "wr_rdata" : "rd_rdata", rsp_rdata, ed);
        chk("rsp_err", rsp_err, ee);
        if (stall > 0) begin
            rsp_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("stall_valid", rsp_valid, 1);
                chk("stall_rdata", rsp_rdata, ed);
                chk("stall_ready", req_ready, 0);
            end
            rsp_ready = 1'b1;
        end
        tick();
        chk("rsp_drop", rsp_valid, 0);
    endtask

    // Count edges from reset release until init_done; nothing may be accepted meanwhile.
    task automatic fill_check(input string tag);
        int n;
        bit ready_low;
        bit no_rsp;
        n = 0;
        ready_low = 1'b1;
        no_rsp = 1'b1;
        while (!init_done && n < 40) begin
            if (req_ready) ready_low = 1'b0;
            tick();
            if (rsp_valid) no_rsp = 1'b0;
            n++;
        end
        chk({tag, "_fill_edges"}, n, DEPTH);
        chk({tag, "_ready_low_in_clear"}, ready_low, 1);
        chk({tag, "_no_rsp_in_clear"}, no_rsp, 1);
        chk({tag, "_ready_after_fill"}, req_ready, 1);
    endtask

    initial begin
        logic [15:0] ed;
        logic        ee;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wren  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        model_zero();

        // Reset values
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_init_done", init_done, 0);

        rst_n = 1'b1;
        fill_check("init");
        for (int a = 0; a < int'(DEPTH); a++) do_req(1'b0, a, 16'h0, 2'b00, 0);

        // Byte lanes
        do_req(1'b1, 3, 16'hA1B2, 2'b11, 0);
        do_req(1'b0, 3, 16'h0, 2'b00, 0);
        do_req(1'b1, 3, 16'hFFC4, 2'b01, 0);
        do_req(1'b0, 3, 16'h0, 2'b00, 0);
        do_req(1'b1, 3, 16'h5555, 2'b00, 0);
        do_req(1'b0, 3, 16'h0, 2'b00, 0);
        chk("lane_model_addr3", ref_mem[3], 16'hA1C4);

        // Back-to-back write then read of the same address
        req_valid = 1'b1;
        req_wren  = 1'b1;
        req_addr  = 4'd5;
        req_wdata = 16'h1234;
        req_be    = 2'b11;
        rsp_ready = 1'b1;
        chk("b2b_ready_wr", req_ready, 1);
        tick();
        model_access(1'b1, 5, 16'h1234, 2'b11, ed, ee);
        chk("b2b_wr_valid", rsp_valid, 1);
        chk("b2b_wr_rdata", rsp_rdata, ed);
        req_wren = 1'b0;
        chk("b2b_ready_rd", req_ready, 1);
        tick();
        model_access(1'b0, 5, 16'h0, 2'b00, ed, ee);
        chk("b2b_rd_valid", rsp_valid, 1);
        chk("b2b_rd_rdata", rsp_rdata, 16'h1234);
        req_valid = 1'b0;
        tick();
        chk("b2b_drop", rsp_valid, 0);

        // Back-pressure on a read of addr 3
        req_valid = 1'b1;
        req_wren  = 1'b0;
        req_addr  = 4'd3;
        rsp_ready = 1'b1;
        chk("bp_ready_initial", req_ready, 1);
        tick();
        model_access(1'b0, 3, 16'h0, 2'b00, ed, ee);
        chk("bp_first_rdata", rsp_rdata, ed);
        rsp_ready = 1'b0;
        req_addr  = 4'd5;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_req_ready_low", req_ready, 0);
            chk("bp_valid_held", rsp_valid, 1);
            chk("bp_rdata_held", rsp_rdata, 16'hA1C4);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_same_cycle", req_ready, 1);
        tick();
        model_access(1'b0, 5, 16'h0, 2'b00, ed, ee);
        chk("bp_next_valid", rsp_valid, 1);
        chk("bp_next_rdata", rsp_rdata, ed);
        req_valid = 1'b0;
        tick();
        chk("bp_drop", rsp_valid, 0);

        // Out of range
        do_req(1'b0, 13, 16'h0, 2'b00, 0);
        do_req(1'b1, 15, 16'hBEEF, 2'b11, 0);
        for (int a = 0; a < int'(DEPTH); a++) do_req(1'b0, a, 16'h0, 2'b00, 0);

        // Mid-operation reset with a pending response and a waiting request
        req_valid = 1'b1;
        req_wren  = 1'b0;
        req_addr  = 4'd3;
        rsp_ready = 1'b1;
        tick();
        chk("mid_pre_valid", rsp_valid, 1);
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_ready", req_ready, 0);
        rst_n = 1'b1;
        model_zero();
        fill_check("mid");
        tick();
        model_access(1'b0, 3, 16'h0, 2'b00, ed, ee);
        chk("mid_after_valid", rsp_valid, 1);
        chk("mid_after_rdata", rsp_rdata, 16'h0000);
        chk("mid_after_err", rsp_err, ee);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            bit          wr;
            int          addr;
            logic [15:0] wd;
            logic [1:0]  be;
            int          stall;
            wr    = 1'($urandom_range(0, 1));
            addr  = int'($urandom_range(0, 15));
            wd    = 16'($urandom);
            be    = 2'($urandom_range(0, 3));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_req(wr, addr, wd, be, stall);
            if ($urandom_range(0, 3) == 0) tick();
        end
        for (int a = 0; a < int'(DEPTH); a++) do_req(1'b0, a, 16'h0, 2'b00, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
